// File: rtl/tloz_input_pkg.sv
// rtl/tloz_input_pkg.sv - shared types and HID key constants for the player input controller
// Purpose: facing direction type, attack FSM states, USB HID usage codes,
//          held-mask bit positions and the direction priority helper.
// Ports:   none (package).
package tloz_input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SWING    = 2'd1,
    ST_COOLDOWN = 2'd2
  } atk_state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_J     = 8'h0D;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  // Held-mask bit positions; the four direction bits line up with dir_t.
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_ATK   = 4;
  localparam int K_START = 5;

  // Highest-priority direction in a 4-bit direction mask (UP > DOWN > LEFT > RIGHT).
  function automatic dir_t pick_dir(input logic [3:0] m);
    if (m[K_UP])        pick_dir = DIR_UP;
    else if (m[K_DOWN]) pick_dir = DIR_DOWN;
    else if (m[K_LEFT]) pick_dir = DIR_LEFT;
    else                pick_dir = DIR_RIGHT;
  endfunction

endpackage

// File: rtl/keycode_input_ctrl_if.sv
// rtl/keycode_input_ctrl_if.sv - keycode in / player control out signal bundle
// Purpose: groups the keycode/frame inputs and player control outputs.
// Ports:   master drives keycode/frame_start and observes the controls;
//          slave is the controller side.
interface keycode_input_ctrl_if;
  logic [15:0] keycode;
  logic        frame_start;
  logic [1:0]  dir;
  logic        moving;
  logic        attack_active;
  logic        attack_start;
  logic        paused;

  modport master (
    output keycode, frame_start,
    input  dir, moving, attack_active, attack_start, paused
  );

  modport slave (
    input  keycode, frame_start,
    output dir, moving, attack_active, attack_start, paused
  );
endinterface

// File: rtl/keycode_slot_decode.sv
// rtl/keycode_slot_decode.sv - one keycode slot to held-key mask
// Purpose: combinational match of one HID usage code against the game keys.
// Ports:   code (8-bit HID usage) -> held (6-bit mask, bit order from package).
module keycode_slot_decode
  import tloz_input_pkg::*;
(
  input  logic [7:0] code,
  output logic [5:0] held
);

  assign held[K_UP]    = (code == KEY_W);
  assign held[K_DOWN]  = (code == KEY_S);
  assign held[K_LEFT]  = (code == KEY_A);
  assign held[K_RIGHT] = (code == KEY_D);
  assign held[K_ATK]   = (code == KEY_J);
  assign held[K_START] = (code == KEY_ENTER);

endmodule

// File: rtl/keycode_input_ctrl.sv
// rtl/keycode_input_ctrl.sv - per-frame keyboard to player movement/attack/pause control
// Purpose: samples the two keycode slots once per video frame, derives facing,
//          walking, sword swing (IDLE/SWING/COOLDOWN) and pause state.
// Ports:   clk_clk, reset_reset_n (async active-low), keycode[15:0], frame_start
//          in; dir[1:0], moving, attack_active, attack_start, paused out (registered).
module keycode_input_ctrl
  import tloz_input_pkg::*;
#(
  parameter int ATTACK_FRAMES   = 12,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] keycode,
  input  logic        frame_start,
  output logic [1:0]  dir,
  output logic        moving,
  output logic        attack_active,
  output logic        attack_start,
  output logic        paused
);

  localparam logic [4:0] ATK_LOAD = 5'(ATTACK_FRAMES - 1);
  localparam logic [4:0] CD_LOAD  = 5'(COOLDOWN_FRAMES - 1);

  logic [5:0] held_lo, held_hi, held, press;
  logic [3:0] dir_held;
  logic       paused_nxt;

  atk_state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [5:0] prev_q, prev_d;
  logic       swing_entry;
  dir_t       dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       active_q, active_d;
  logic       start_q, start_d;
  logic       paused_q, paused_d;

  keycode_slot_decode u_slot0 (.code(keycode[7:0]),  .held(held_lo));
  keycode_slot_decode u_slot1 (.code(keycode[15:8]), .held(held_hi));

  assign held     = held_lo | held_hi;
  assign press    = held & ~prev_q;
  assign dir_held = held[3:0];
  // Pause state as it will stand after this frame; gating uses this so the
  // frame carrying the Enter edge is already frozen (or already running).
  assign paused_nxt = paused_q ^ press[K_START];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      dir_q    <= DIR_DOWN;
      moving_q <= 1'b0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      active_q <= active_d;
      start_q  <= start_d;
      paused_q <= paused_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    swing_entry = 1'b0;
    if (frame_start) begin
      prev_d = held;
      if (!paused_nxt) begin
        case (state_q)
          ST_IDLE: begin
            // An attack edge sharing its frame with an Enter edge is dropped.
            if (press[K_ATK] && !press[K_START]) begin
              state_d     = ST_SWING;
              cnt_d       = ATK_LOAD;
              swing_entry = 1'b1;
            end
          end
          ST_SWING: begin
            if (cnt_q == 5'd0) begin
              state_d = ST_COOLDOWN;
              cnt_d   = CD_LOAD;
            end else begin
              cnt_d = cnt_q - 5'd1;
            end
          end
          ST_COOLDOWN: begin
            if (cnt_q == 5'd0) state_d = ST_IDLE;
            else               cnt_d   = cnt_q - 5'd1;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    dir_d    = dir_q;
    moving_d = moving_q;
    active_d = active_q;
    start_d  = 1'b0;
    paused_d = paused_q;
    if (frame_start) begin
      paused_d = paused_nxt;
      start_d  = swing_entry;
      active_d = (state_d == ST_SWING);
      moving_d = (|dir_held) && !paused_nxt && (state_d != ST_SWING);
      if (|press[3:0])
        dir_d = pick_dir(press[3:0]);
      else if (!dir_held[dir_q] && (|dir_held))
        dir_d = pick_dir(dir_held);
    end
  end

  assign dir           = dir_q;
  assign moving        = moving_q;
  assign attack_active = active_q;
  assign attack_start  = start_q;
  assign paused        = paused_q;

endmodule

// File: tb/tb_keycode_input_ctrl.sv
// tb/tb_keycode_input_ctrl.sv - self-checking bench for keycode_input_ctrl
module tb_keycode_input_ctrl;

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_item_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  sb_item_t sb[$];

  keycode_input_ctrl_if bus ();

  keycode_input_ctrl #(.ATTACK_FRAMES(12), .COOLDOWN_FRAMES(8)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .keycode       (bus.keycode),
    .frame_start   (bus.frame_start),
    .dir           (bus.dir),
    .moving        (bus.moving),
    .attack_active (bus.attack_active),
    .attack_start  (bus.attack_start),
    .paused        (bus.paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {dir, moving, attack_active, attack_start, paused}
  function automatic logic [5:0] obs();
    return {bus.dir, bus.moving, bus.attack_active, bus.attack_start, bus.paused};
  endfunction

  task automatic cmp(input string tag, input logic [5:0] exp);
    logic [5:0] o;
    o = obs();
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s observed dir/mov/act/start/pause=%b expected=%b", tag, o, exp);
    end
  endtask

  task automatic pop_check();
    sb_item_t it;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end else begin
      it = sb.pop_front();
      cmp(it.tag, it.exp);
    end
  endtask

  // One evaluated frame: expectation pushed when driven, checked the cycle
  // after, then checked again a cycle later (attack_start must be gone).
  task automatic frame(input logic [15:0] kc, input logic [1:0] d, input logic m,
                       input logic a, input logic s, input logic p, input string tag);
    @(negedge clk);
    bus.keycode     = kc;
    bus.frame_start = 1'b1;
    sb.push_back('{tag, {d, m, a, s, p}});
    @(negedge clk);
    bus.frame_start = 1'b0;
    pop_check();
    @(negedge clk);
    cmp({tag, "_hold"}, {d, m, a, 1'b0, p});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.keycode     = 16'h0000;
    bus.frame_start = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    cmp("reset_state", {2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    rst_n = 1'b1;
    @(negedge clk);

    // Direction handling.
    frame(16'h001A, 2'd0, 1, 0, 0, 0, "w_press");
    frame(16'h1A07, 2'd3, 1, 0, 0, 0, "d_last_pressed");
    frame(16'h1A00, 2'd0, 1, 0, 0, 0, "d_release_fallback_up");
    frame(16'h0000, 2'd0, 0, 0, 0, 0, "none_held_retain");
    frame(16'h1604, 2'd1, 1, 0, 0, 0, "s_a_same_frame_down");
    frame(16'h0000, 2'd1, 0, 0, 0, 0, "release_all");

    // Keycode changes between frame pulses are ignored.
    @(negedge clk);
    bus.keycode = 16'h0007;
    repeat (3) @(negedge clk);
    cmp("between_pulses_1", {2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    bus.keycode = 16'h0D28;
    repeat (2) @(negedge clk);
    cmp("between_pulses_2", {2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    frame(16'h0000, 2'd1, 0, 0, 0, 0, "after_gap");

    // Swing with W held: 12 active frames, then 8 cooldown frames.
    frame(16'h1A0D, 2'd0, 0, 1, 1, 0, "swing_entry");
    for (int i = 1; i <= 11; i++)
      frame(16'h1A0D, 2'd0, 0, 1, 0, 0, $sformatf("swing_f%0d", i));
    frame(16'h1A0D, 2'd0, 1, 0, 0, 0, "cooldown_f12");
    frame(16'h001A, 2'd0, 1, 0, 0, 0, "cooldown_j_release");
    frame(16'h1A0D, 2'd0, 1, 0, 0, 0, "cooldown_j_edge_ignored");
    for (int i = 15; i <= 20; i++)
      frame(16'h1A0D, 2'd0, 1, 0, 0, 0, $sformatf("cooldown_f%0d", i));
    frame(16'h1A0D, 2'd0, 1, 0, 0, 0, "idle_j_held_no_retrigger");
    frame(16'h0000, 2'd0, 0, 0, 0, 0, "idle_release");

    // Pause mid-swing freezes the counter.
    frame(16'h000D, 2'd0, 0, 1, 1, 0, "p_swing_entry");
    for (int i = 1; i <= 4; i++)
      frame(16'h000D, 2'd0, 0, 1, 0, 0, $sformatf("p_swing_f%0d", i));
    frame(16'h0D28, 2'd0, 0, 1, 0, 1, "p_pause");
    frame(16'h000D, 2'd0, 0, 1, 0, 1, "p_frozen_1");
    frame(16'h000D, 2'd0, 0, 1, 0, 1, "p_frozen_2");
    frame(16'h0D28, 2'd0, 0, 1, 0, 0, "p_resume");
    for (int i = 1; i <= 6; i++)
      frame(16'h0000, 2'd0, 0, 1, 0, 0, $sformatf("p_remaining_%0d", i));
    frame(16'h0000, 2'd0, 0, 0, 0, 0, "p_swing_done");
    for (int i = 1; i <= 8; i++)
      frame(16'h0000, 2'd0, 0, 0, 0, 0, $sformatf("p_cooldown_%0d", i));

    // Enter and J in the same frame; facing still updates while paused.
    frame(16'h0D28, 2'd0, 0, 0, 0, 1, "enter_j_same_frame");
    frame(16'h0000, 2'd0, 0, 0, 0, 1, "paused_idle");
    frame(16'h0007, 2'd3, 0, 0, 0, 1, "paused_dir_update");
    frame(16'h000D, 2'd3, 0, 0, 0, 1, "paused_j_no_start");
    frame(16'h0028, 2'd3, 0, 0, 0, 0, "unpause");
    frame(16'h0000, 2'd3, 0, 0, 0, 0, "unpaused_idle");

    // Reset in the middle of cooldown with J held throughout.
    frame(16'h000D, 2'd3, 0, 1, 1, 0, "r_swing_entry");
    for (int i = 1; i <= 11; i++)
      frame(16'h000D, 2'd3, 0, 1, 0, 0, $sformatf("r_swing_f%0d", i));
    frame(16'h000D, 2'd3, 0, 0, 0, 0, "r_cooldown_1");
    frame(16'h000D, 2'd3, 0, 0, 0, 0, "r_cooldown_2");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset_immediate", {2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    cmp("frame_ignored_in_reset", {2'd1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    frame(16'h000D, 2'd1, 0, 1, 1, 0, "post_reset_j_edge");
    frame(16'h000D, 2'd1, 0, 1, 0, 0, "post_reset_swing");

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d left expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
